muldiv_adder_seq: RTL and testbench
===================================

Name: muldiv_adder_seq

Overview:
- Iterative unsigned multiply/divide sequencer for the RV32M path. Does 32 radix-2 iterations.
- Owns no arithmetic of its own: each cycle it drives the operands of one external 32-bit carry-lookahead adder_32_bit instance and consumes its sum and carry-out.
- Sits beside the ALU in EX. The pipeline stalls on busy and captures result on done.

Parameters:
- WIDTH, 32, operand/result width. Must equal the adder width; only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
- op_a  input  WIDTH  multiplicand / dividend; sampled with start
- op_b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  single-cycle pulse, result valid
- result  output  WIDTH  final value; held until next accepted start
- add_a  output  WIDTH  adder operand A
- add_b  output  WIDTH  adder operand B
- add_cin  output  1  adder carry-in
- add_sum  input  WIDTH  adder sum
- add_cout  input  1  adder carry-out

Behaviour:
- Interface: one clock (clk); rst_n is asynchronous, active-low.
- Reset (any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0.
  - Counter and internal registers hi, lo, opnd cleared to 0.
  - add_a=0, add_b=0, add_cin=0.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - start=1 latches op, opnd<=op_b, counter<=0.
  - MUL/MULHU: hi<=0, lo<=op_a.
  - DIVU/REMU: hi<=0, lo<=op_a.
  - Next state CALC.
  - Divide by zero (op[1]=1 and op_b=0) skips CALC and goes straight to DONE: result=0xFFFFFFFF for DIVU, op_a for REMU.
- CALC, multiply step:
  - add_a=hi, add_b=lo[0]?opnd:0, add_cin=0.
  - {hi,lo} <= {add_cout, add_sum, lo} >> 1 (65-bit shift, keep low 64).
- CALC, divide step:
  - add_a={hi[30:0],lo[31]}, add_b=~opnd, add_cin=1.
  - Let ge = hi[31] | add_cout.
  - hi <= ge ? add_sum : {hi[30:0],lo[31]}.
  - lo <= {lo[30:0],ge}.
- CALC iteration control: counter increments every CALC cycle. After the 32nd CALC cycle (counter==31), next state is DONE.
- DONE:
  - done=1 for exactly one cycle; busy=1.
  - result <= MUL: lo; MULHU: hi; DIVU: lo; REMU: hi. Result is registered so it is valid in the same cycle done=1.
  - Next state IDLE.
- Latency: start accepted at edge 0 -> done high in the cycle after edge 33 (32 CALC + 1 DONE). Divide-by-zero: done after edge 1.
- start while busy=1 is ignored, with no queuing. start in the DONE cycle is also ignored.
- Outside CALC, add_a/add_b/add_cin are driven to 0. Adder outputs are then don't-care.
- Operands and op are registered at start. Changes on op_a/op_b/op during busy have no effect.

Optional Feature:
- MULDIV_ZERO_SKIP_EN
- Defined:
  - MUL/MULHU with op_a==0 or op_b==0 goes IDLE->DONE with result 0.
  - DIVU/REMU with op_a<op_b (internal unsigned compare at start) goes IDLE->DONE with quotient 0 / remainder op_a.
  - Latency for these cases is 1 cycle to done.
- Undefined: only divide-by-zero shortcuts. All other operations take the full 32 CALC cycles.

Test Plan:
- MUL 7*6, start at edge 0 -> busy=1 edges 1-33, done=1 once after edge 33, result=0x0000002A; MULHU same operands -> 0x00000000.
- MUL/MULHU 0xFFFFFFFF*0xFFFFFFFF -> MUL=0x00000001, MULHU=0xFFFFFFFE; check add_cout path every cycle via adder operand monitor.
- DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 0xFFFFFFFE/0x80000001 -> 0x00000001, REMU -> 0x7FFFFFFD (hi[31] path).
- DIVU 0x12345678/0 -> 0xFFFFFFFF, REMU -> 0x12345678, done after edge 1; repeated start while busy -> ignored, single done.
- Assert rst_n=0 mid-CALC (edge 10) -> busy, done, result, add_* =0 immediately; new MUL 3*5 after release -> 0x0000000F in 33 cycles.
- With MULDIV_ZERO_SKIP_EN: MUL 0*0xDEADBEEF -> 0 in 1 cycle; REMU 5/9 -> 5 in 1 cycle. Without the macro: same results in 33 cycles.

Source files
------------

// File: rtl/muldiv_adder_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer driving an external 32-bit adder.
// Optional macro MULDIV_ZERO_SKIP_EN adds one-cycle shortcuts for trivial operands.
`timescale 1ns/1ps
module muldiv_adder_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] hi, hi_d, lo, lo_d, opnd, opnd_d, result_d;
    logic [1:0]       op_q, op_d;
    logic             ge;
    logic             div_zero, skip_mul, skip_div, shortcut;

    assign div_zero = op[1] && (op_b == '0);
`ifdef MULDIV_ZERO_SKIP_EN
    assign skip_mul = !op[1] && ((op_a == '0) || (op_b == '0));
    assign skip_div = op[1] && (op_a < op_b);
`else
    assign skip_mul = 1'b0;
    assign skip_div = 1'b0;
`endif
    assign shortcut = div_zero || skip_mul || skip_div;

    // Handshake: start is accepted only in IDLE; busy stays high from the following
    // cycle through the single done cycle, and result is valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = shortcut ? DONE : CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == CALC) begin
            if (op_q[1]) begin
                add_a   = {hi[WIDTH-2:0], lo[WIDTH-1]};
                add_b   = ~opnd;
                add_cin = 1'b1;
            end else begin
                add_a = hi;
                add_b = lo[0] ? opnd : '0;
            end
        end
    end

    // Datapath next values; shortcut cases preload hi/lo so DONE reads the answer directly.
    always_comb begin
        hi_d   = hi;
        lo_d   = lo;
        opnd_d = opnd;
        op_d   = op_q;
        cnt_d  = cnt;
        ge     = 1'b0;
        case (state)
            IDLE: if (start) begin
                op_d   = op;
                opnd_d = op_b;
                cnt_d  = '0;
                hi_d   = '0;
                lo_d   = op_a;
                if (div_zero) begin
                    hi_d = op_a;
                    lo_d = '1;
                end else if (skip_mul) begin
                    lo_d = '0;
                end else if (skip_div) begin
                    hi_d = op_a;
                    lo_d = '0;
                end
            end
            CALC: begin
                cnt_d = cnt + 1'b1;
                if (op_q[1]) begin
                    // hi[31] set means the 33-bit partial remainder already exceeds any divisor
                    ge   = hi[WIDTH-1] | add_cout;
                    hi_d = ge ? add_sum : {hi[WIDTH-2:0], lo[WIDTH-1]};
                    lo_d = {lo[WIDTH-2:0], ge};
                end else begin
                    hi_d = {add_cout, add_sum[WIDTH-1:1]};
                    lo_d = {add_sum[0], lo[WIDTH-1:1]};
                end
            end
            default: ;
        endcase
    end

    // op[0] selects the high word (MULHU/REMU), otherwise the low word (MUL/DIVU).
    always_comb begin
        result_d = result;
        if (state_nxt == DONE) result_d = op_d[0] ? hi_d : lo_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            op_q   <= '0;
            result <= '0;
        end else begin
            cnt    <= cnt_d;
            hi     <= hi_d;
            lo     <= lo_d;
            opnd   <= opnd_d;
            op_q   <= op_d;
            result <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_adder_seq.sv
// Self-checking bench for muldiv_adder_seq with a behavioural 32-bit adder attached.
// Expected latencies follow MULDIV_ZERO_SKIP_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_muldiv_adder_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, add_cin, add_cout;
    logic [W-1:0] result, add_a, add_b, add_sum;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    muldiv_adder_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] a, b);
        if (o[1] && b == 0) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
        if (!o[1] && (a == 0 || b == 0)) return 1;
        if (o[1] && a < b) return 1;
`endif
        return 33;
    endfunction

    task automatic scramble(input bit keep_start);
        start = keep_start;
        op    = 2'($urandom_range(0, 3));
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Drive one operation; poke=1 keeps hammering start with junk while busy and in DONE.
    task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a, b,
                         input bit poke);
        int lat;
        int want_lat;
        logic [W-1:0] exp;
        want_lat = exp_lat(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        scramble(poke);
        lat = 1;
        while (!done && lat < 100) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy_calc: got %b want 1 (cycle %0d)", name, busy, lat);
            end
            n_cmp++;
            if (o[1] ? (add_b !== ~b || add_cin !== 1'b1)
                     : ((add_b !== b && add_b !== '0) || add_cin !== 1'b0)) begin
                n_err++;
                $display("FAIL %s adder_ops: add_b=%h cin=%b for b=%h (cycle %0d)",
                         name, add_b, add_cin, b, lat);
            end
            @(negedge clk);
            lat++;
            if (poke) scramble(1'b1);
            else      scramble(1'b0);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout: done never rose within %0d cycles", name, lat);
        end
        n_cmp++;
        if (lat != want_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
        end
        n_cmp++;
        if (result !== exp) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, result, exp);
        end
        n_cmp++;
        if (busy !== 1'b1 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_cycle: busy=%b add_a=%h add_b=%h cin=%b want 1/0/0/0",
                     name, busy, add_a, add_b, add_cin);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: done=%b busy=%b want 0/0", name, done, busy);
        end
        n_cmp++;
        if (result !== exp) begin
            n_err++;
            $display("FAIL %s result_hold: got %h want %h", name, result, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 ||
            add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b result=%h add_a=%h add_b=%h cin=%b want all 0",
                     busy, done, result, add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_mul();
        do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 1'b0);
        do_op("mulhu_7x6", 2'b01, 32'd7, 32'd6, 1'b0);
        do_op("mul_ffxff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mulhu_ffxff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mulhu_big", 2'b01, 32'h8000_0001, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_div();
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        do_op("divu_hi31", 2'b10, 32'hFFFF_FFFE, 32'h8000_0001, 1'b0);
        do_op("remu_hi31", 2'b11, 32'hFFFF_FFFE, 32'h8000_0001, 1'b0);
        do_op("divu_by1", 2'b10, 32'hCAFE_F00D, 32'd1, 1'b0);
    endtask

    task automatic test_div_zero();
        do_op("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 1'b0);
        do_op("remu_zero", 2'b11, 32'h1234_5678, 32'd0, 1'b0);
    endtask

    task automatic test_busy_start();
        do_op("busy_divu", 2'b10, 32'd100, 32'd7, 1'b1);
        do_op("busy_mul", 2'b00, 32'd1000, 32'd1000, 1'b1);
        do_op("busy_divz", 2'b11, 32'h0BAD_F00D, 32'd0, 1'b1);
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        start = 1'b1; op = 2'b00; op_a = 32'h1234; op_b = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 ||
            add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h add_a=%h add_b=%h cin=%b want all 0",
                     busy, done, result, add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op("mul_3x5_after_rst", 2'b00, 32'd3, 32'd5, 1'b0);
    endtask

    task automatic test_zero_skip();
        do_op("mul_zero_a", 2'b00, 32'd0, 32'hDEAD_BEEF, 1'b0);
        do_op("mulhu_zero_b", 2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0);
        do_op("remu_5_9", 2'b11, 32'd5, 32'd9, 1'b0);
        do_op("divu_5_9", 2'b10, 32'd5, 32'd9, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]   o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 255));
                1:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op("random", o, a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_busy_start();
        test_reset_mid_calc();
        test_zero_skip();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
